// File: rtl/nano_mem_loader.sv
// NanoCPU bus memory responder with an embedded byte-stream program loader.
// While a load is in progress the CPU is held in reset and locked out of the array.
module nano_mem_loader #(
    parameter int unsigned           ADDR_W        = 8,
    parameter logic [ADDR_W-1:0]     LOAD_BASE     = '0,
    parameter bit                    HOLD_AT_RESET = 1'b1
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              ce,
    input  logic              we,
    input  logic [ADDR_W-1:0] address,
    input  logic [15:0]       dataW,
    output logic [15:0]       dataR,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic [15:0]       load_sum,
    output logic              cpu_hold
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, RX_HI, RX_LO} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [ADDR_W:0]     cnt, cnt_nxt;
    logic [ADDR_W:0]     len_q, len_nxt;
    logic [7:0]          hi, hi_nxt;
    logic [15:0]         sum_nxt;
    logic                hold_nxt;
    logic                done_nxt;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [15:0]         mem_wdata;
    logic [15:0]         mem [DEPTH];

    assign load_busy = (state != IDLE);
    assign dataR     = load_busy ? '0 : mem[address];

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cnt_nxt    = cnt;
        len_nxt    = len_q;
        hi_nxt     = hi;
        sum_nxt    = load_sum;
        hold_nxt   = cpu_hold;
        done_nxt   = 1'b0;
        load_ready = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = address;
        mem_wdata  = dataW;
        unique case (state)
            IDLE: begin
                // CPU port owns the array only while no load is running
                mem_we = ce && we;
                if (load_start) begin
                    sum_nxt = '0;
                    if (load_len != '0) begin
                        state_nxt = RX_HI;
                        ptr_nxt   = LOAD_BASE;
                        cnt_nxt   = '0;
                        len_nxt   = load_len;
                        hold_nxt  = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                        hold_nxt = 1'b0;
                    end
                end
            end
            RX_HI: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    hi_nxt    = load_byte;
                    state_nxt = RX_LO;
                end
            end
            RX_LO: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = ptr;
                    mem_wdata = {hi, load_byte};
                    sum_nxt   = load_sum + {hi, load_byte};
                    ptr_nxt   = ptr + 1'b1;
                    cnt_nxt   = cnt + 1'b1;
                    if (cnt == len_q - 1'b1) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        hold_nxt  = 1'b0;
                    end else begin
                        state_nxt = RX_HI;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= LOAD_BASE;
            cnt       <= '0;
            len_q     <= '0;
            hi        <= '0;
            load_sum  <= '0;
            load_done <= 1'b0;
            cpu_hold  <= HOLD_AT_RESET;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            len_q     <= len_nxt;
            hi        <= hi_nxt;
            load_sum  <= sum_nxt;
            load_done <= done_nxt;
            cpu_hold  <= hold_nxt;
        end
    end

    // Array is deliberately outside the reset domain so a program survives reset
    always_ff @(posedge ck) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

endmodule

// File: tb/tb_nano_mem_loader.sv
// Bench for nano_mem_loader: two instances (base 00/hold 1 and base FF/hold 0)
// share one stimulus stream and are checked against a word-level model every cycle.
module tb_nano_mem_loader;

    logic        ck = 1'b0;
    logic        rst;
    logic        ce, we;
    logic [7:0]  address;
    logic [15:0] dataW;
    logic        load_start;
    logic [8:0]  load_len;
    logic        load_valid;
    logic [7:0]  load_byte;

    logic [15:0] dataR_w [2];
    logic        ready_w [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [15:0] sum_w   [2];
    logic        hold_w  [2];

    int total = 0;
    int bad   = 0;
    bit run   = 1'b0;

    always #5 ck = ~ck;

    nano_mem_loader #(.ADDR_W(8), .LOAD_BASE(8'h00), .HOLD_AT_RESET(1'b1)) u_a (
        .ck(ck), .rst(rst), .ce(ce), .we(we), .address(address), .dataW(dataW),
        .dataR(dataR_w[0]), .load_start(load_start), .load_len(load_len),
        .load_valid(load_valid), .load_byte(load_byte), .load_ready(ready_w[0]),
        .load_busy(busy_w[0]), .load_done(done_w[0]), .load_sum(sum_w[0]),
        .cpu_hold(hold_w[0])
    );

    nano_mem_loader #(.ADDR_W(8), .LOAD_BASE(8'hFF), .HOLD_AT_RESET(1'b0)) u_b (
        .ck(ck), .rst(rst), .ce(ce), .we(we), .address(address), .dataW(dataW),
        .dataR(dataR_w[1]), .load_start(load_start), .load_len(load_len),
        .load_valid(load_valid), .load_byte(load_byte), .load_ready(ready_w[1]),
        .load_busy(busy_w[1]), .load_done(done_w[1]), .load_sum(sum_w[1]),
        .cpu_hold(hold_w[1])
    );

    task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Word-level model: a load is "words_left" words, each made of two accepted bytes
    logic [7:0]  base [2];
    logic [15:0] mmem   [2][256];
    bit          mknown [2][256];
    bit          m_loading, m_have_hi, m_done;
    bit          m_hold [2];
    logic [7:0]  m_hi;
    int          m_left, m_k;
    logic [15:0] m_sum;

    initial begin
        base[0] = 8'h00;
        base[1] = 8'hFF;
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 256; a++) mknown[i][a] = 1'b0;
    end

    always @(posedge ck or negedge rst) begin
        if (!rst) begin
            m_loading = 1'b0;
            m_have_hi = 1'b0;
            m_done    = 1'b0;
            m_sum     = '0;
            m_hold[0] = 1'b1;
            m_hold[1] = 1'b0;
        end else begin
            bit done_n;
            done_n = 1'b0;
            if (!m_loading) begin
                if (ce && we)
                    for (int i = 0; i < 2; i++) begin
                        mmem[i][address]   = dataW;
                        mknown[i][address] = 1'b1;
                    end
                if (load_start) begin
                    m_sum = '0;
                    if (load_len == 0) begin
                        done_n = 1'b1;
                        m_hold[0] = 1'b0;
                        m_hold[1] = 1'b0;
                    end else begin
                        m_loading = 1'b1;
                        m_left    = int'(load_len);
                        m_k       = 0;
                        m_have_hi = 1'b0;
                        m_hold[0] = 1'b1;
                        m_hold[1] = 1'b1;
                    end
                end
            end else if (load_valid) begin
                if (!m_have_hi) begin
                    m_hi      = load_byte;
                    m_have_hi = 1'b1;
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        logic [7:0] wa;
                        wa = base[i] + 8'(m_k);
                        mmem[i][wa]   = {m_hi, load_byte};
                        mknown[i][wa] = 1'b1;
                    end
                    m_sum     = m_sum + {m_hi, load_byte};
                    m_k       = m_k + 1;
                    m_have_hi = 1'b0;
                    m_left    = m_left - 1;
                    if (m_left == 0) begin
                        m_loading = 1'b0;
                        done_n    = 1'b1;
                        m_hold[0] = 1'b0;
                        m_hold[1] = 1'b0;
                    end
                end
            end
            m_done = done_n;
        end
    end

    always @(negedge ck) begin
        if (run) begin
            for (int i = 0; i < 2; i++) begin
                chk("busy",  i, 16'(busy_w[i]),  16'(m_loading));
                chk("ready", i, 16'(ready_w[i]), 16'(m_loading));
                chk("done",  i, 16'(done_w[i]),  16'(m_done));
                chk("sum",   i, sum_w[i],        m_sum);
                chk("hold",  i, 16'(hold_w[i]),  16'(m_hold[i]));
                if (m_loading)
                    chk("dataR_busy", i, dataR_w[i], 16'h0000);
                else if (mknown[i][address])
                    chk("dataR", i, dataR_w[i], mmem[i][address]);
            end
        end
    end

    task automatic step();
        @(posedge ck);
        #2;
    endtask

    task automatic peek(input logic [7:0] a, input logic [15:0] e0, input logic [15:0] e1);
        ce = 1'b0; we = 1'b0; address = a;
        @(negedge ck);
        chk("lit_peek", 0, dataR_w[0], e0);
        chk("lit_peek", 1, dataR_w[1], e1);
        step();
    endtask

    task automatic send(input logic [7:0] b);
        load_valid = 1'b1;
        load_byte  = b;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; we = 1'b0; address = '0; dataW = '0;
        load_start = 1'b0; load_len = '0; load_valid = 1'b0; load_byte = '0;
        #1 run = 1'b1;
        @(negedge ck);
        chk("lit_rst_hold", 0, 16'(hold_w[0]), 16'h1);
        chk("lit_rst_hold", 1, 16'(hold_w[1]), 16'h0);
        chk("lit_rst_busy", 0, 16'(busy_w[0]), 16'h0);
        chk("lit_rst_ready", 0, 16'(ready_w[0]), 16'h0);
        chk("lit_rst_sum", 0, sum_w[0], 16'h0000);
        step();
        rst = 1'b1;
        step();

        for (int a = 0; a < 256; a++) begin
            ce = 1'b1; we = 1'b1; address = 8'(a);
            dataW = {8'(a), 8'(a)} ^ 16'h5A00;
            step();
        end
        ce = 1'b0; we = 1'b0;

        // CPU write, then an un-enabled write to the same word
        ce = 1'b1; we = 1'b1; address = 8'h1E; dataW = 16'h1111;
        step();
        ce = 1'b0; dataW = 16'h2222;
        step();
        peek(8'h1E, 16'h1111, 16'h1111);

        // Basic load: 01E0, 01F1
        load_start = 1'b1; load_len = 9'd2;
        step();
        load_start = 1'b0;
        send(8'h01); send(8'hE0); send(8'h01); send(8'hF1);
        @(negedge ck);
        chk("lit_done", 0, 16'(done_w[0]), 16'h1);
        chk("lit_sum", 0, sum_w[0], 16'h03D1);
        chk("lit_hold", 0, 16'(hold_w[0]), 16'h0);
        step();
        @(negedge ck);
        chk("lit_done_off", 0, 16'(done_w[0]), 16'h0);
        step();
        peek(8'h00, 16'h01E0, 16'h01F1);
        peek(8'h01, 16'h01F1, 16'h5B01);
        peek(8'hFF, 16'hA5FF, 16'h01E0);

        // CPU write and second load_start while busy, with byte gaps
        load_start = 1'b1; load_len = 9'd1;
        step();
        ce = 1'b1; we = 1'b1; address = 8'h05; dataW = 16'hBEEF;
        load_start = 1'b1; load_len = 9'd3;
        @(negedge ck);
        chk("lit_dataR_busy", 0, dataR_w[0], 16'h0000);
        step();
        load_start = 1'b0; ce = 1'b0; we = 1'b0;
        send(8'h12);
        step();
        send(8'h34);
        step();
        peek(8'h05, 16'h5F05, 16'h5F05);
        peek(8'h00, 16'h1234, 16'h01F1);
        peek(8'hFF, 16'hA5FF, 16'h1234);

        // Load started together with an IDLE CPU write; B wraps FF -> 00
        load_start = 1'b1; load_len = 9'd2;
        ce = 1'b1; we = 1'b1; address = 8'h40; dataW = 16'h4040;
        step();
        load_start = 1'b0; ce = 1'b0; we = 1'b0;
        send(8'hAA); send(8'hAA); send(8'h55); send(8'h55);
        @(negedge ck);
        chk("lit_sum_wrap", 1, sum_w[1], 16'hFFFF);
        step();
        peek(8'hFF, 16'hA5FF, 16'hAAAA);
        peek(8'h00, 16'hAAAA, 16'h5555);
        peek(8'h01, 16'h5555, 16'h5B01);
        peek(8'h40, 16'h4040, 16'h4040);

        // Zero-length load
        load_start = 1'b1; load_len = 9'd0;
        step();
        load_start = 1'b0;
        @(negedge ck);
        chk("lit_done_len0", 0, 16'(done_w[0]), 16'h1);
        chk("lit_sum_len0", 0, sum_w[0], 16'h0000);
        step();

        // Bytes offered in IDLE are ignored
        load_valid = 1'b1; load_byte = 8'hFF;
        repeat (3) step();
        load_valid = 1'b0;

        // Reset after three bytes of a two-word load
        load_start = 1'b1; load_len = 9'd2;
        step();
        load_start = 1'b0;
        send(8'h77); send(8'h88); send(8'h99);
        rst = 1'b0;
        @(negedge ck);
        chk("lit_midrst_hold", 0, 16'(hold_w[0]), 16'h1);
        chk("lit_midrst_hold", 1, 16'(hold_w[1]), 16'h0);
        chk("lit_midrst_busy", 0, 16'(busy_w[0]), 16'h0);
        step();
        rst = 1'b1;
        repeat (3) step();
        peek(8'h00, 16'h7788, 16'h5555);
        peek(8'h01, 16'h5555, 16'h5B01);
        peek(8'hFF, 16'hA5FF, 16'h7788);

        repeat (2) step();
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
